// File: rtl/pipeline_stall_controller_if.sv
// Handshake bundle between the datapath hazard taps and the stall/flush sequencer.
// The slave modport is the controller side; the master modport is the datapath side.
interface pipeline_stall_controller_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] rd_ex;
  logic [REG_ADDR_W-1:0] rs1_id;
  logic [REG_ADDR_W-1:0] rs2_id;
  logic                  rs1_used_id;
  logic                  rs2_used_id;
  logic                  mem_read_ex;
  logic                  branch_taken_ex;
  logic                  mem_access_mem;
  logic                  pc_write;
  logic                  if_id_write;
  logic                  if_id_flush;
  logic                  id_ex_write;
  logic                  id_ex_bubble;
  logic                  ex_mem_write;
  logic                  mem_wb_bubble;
  logic                  busy;

  modport master (
    output rd_ex, rs1_id, rs2_id, rs1_used_id, rs2_used_id,
           mem_read_ex, branch_taken_ex, mem_access_mem,
    input  pc_write, if_id_write, if_id_flush, id_ex_write,
           id_ex_bubble, ex_mem_write, mem_wb_bubble, busy
  );

  modport slave (
    input  rd_ex, rs1_id, rs2_id, rs1_used_id, rs2_used_id,
           mem_read_ex, branch_taken_ex, mem_access_mem,
    output pc_write, if_id_write, if_id_flush, id_ex_write,
           id_ex_bubble, ex_mem_write, mem_wb_bubble, busy
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch, multi-cycle MEM.
// Optional macro STALL_STATS_EN adds saturating stall_cycles / flush_count statistics.
module pipeline_stall_controller #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_LATENCY = 3,
  parameter int CNT_W       = 32
) (
  input  logic                      clk,
  input  logic                      arst_n,
`ifdef STALL_STATS_EN
  output logic [CNT_W-1:0]          stall_cycles,
  output logic [CNT_W-1:0]          flush_count,
`endif
  pipeline_stall_controller_if.slave sc
);

  typedef enum logic {
    S_RUN      = 1'b0,
    S_MEM_WAIT = 1'b1
  } state_t;

  localparam logic [REG_ADDR_W-1:0] REG_X0    = '0;
  localparam bit                    MULTI_CYC = (MEM_LATENCY > 1);
  localparam logic [3:0]            WAIT_INIT = 4'(MULTI_CYC ? MEM_LATENCY - 2 : 0);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t     state, state_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic       lu;

  assign lu = sc.mem_read_ex && (sc.rd_ex != REG_X0) &&
              ((sc.rs1_used_id && (sc.rd_ex == sc.rs1_id)) ||
               (sc.rs2_used_id && (sc.rd_ex == sc.rs2_id)));

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state    <= S_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    wait_cnt_nxt     = wait_cnt;
    sc.pc_write      = 1'b1;
    sc.if_id_write   = 1'b1;
    sc.if_id_flush   = 1'b0;
    sc.id_ex_write   = 1'b1;
    sc.id_ex_bubble  = 1'b0;
    sc.ex_mem_write  = 1'b1;
    sc.mem_wb_bubble = 1'b0;
    sc.busy          = 1'b0;

    if (arst_n) begin
      sc.busy = (state == S_MEM_WAIT);
      // A pending access freezes everything upstream of MEM and bubbles into WB.
      if ((state == S_RUN && sc.mem_access_mem && MULTI_CYC) ||
          (state == S_MEM_WAIT && wait_cnt != 4'd0)) begin
        sc.pc_write      = 1'b0;
        sc.if_id_write   = 1'b0;
        sc.id_ex_write   = 1'b0;
        sc.ex_mem_write  = 1'b0;
        sc.mem_wb_bubble = 1'b1;
        if (state == S_RUN) begin
          state_nxt    = S_MEM_WAIT;
          wait_cnt_nxt = WAIT_INIT;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end else begin
        // Run or release cycle: the access (if any) is done, so no retrigger here.
        state_nxt = S_RUN;
        if (sc.branch_taken_ex) begin
          sc.if_id_flush  = 1'b1;
          sc.id_ex_bubble = 1'b1;
        end else if (lu) begin
          sc.pc_write     = 1'b0;
          sc.if_id_write  = 1'b0;
          sc.id_ex_bubble = 1'b1;
        end
      end
    end
  end

`ifdef STALL_STATS_EN
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!sc.pc_write)   stall_cycles <= sat_inc(stall_cycles);
      if (sc.if_id_flush) flush_count  <= sat_inc(flush_count);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller (MEM_LATENCY=3 main DUT, MEM_LATENCY=1 side DUT).
module tb_pipeline_stall_controller;

  localparam logic [7:0] V_IDLE   = 8'b1101_0100;
  localparam logic [7:0] V_FRZ    = 8'b0000_0010;
  localparam logic [7:0] V_FRZ_B  = 8'b0000_0011;
  localparam logic [7:0] V_REL    = 8'b1101_0101;
  localparam logic [7:0] V_LU     = 8'b0001_1100;
  localparam logic [7:0] V_BR     = 8'b1111_1100;
  localparam logic [7:0] V_REL_BR = 8'b1111_1101;

  logic       clk = 1'b0;
  logic       arst_n;
  logic [4:0] rd_ex, rs1_id, rs2_id;
  logic       rs1_used_id, rs2_used_id, mem_read_ex, branch_taken_ex, mem_access_mem;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller_if #(.REG_ADDR_W(5)) bus3 ();
  pipeline_stall_controller_if #(.REG_ADDR_W(5)) bus1 ();

  assign bus3.rd_ex = rd_ex;             assign bus1.rd_ex = rd_ex;
  assign bus3.rs1_id = rs1_id;           assign bus1.rs1_id = rs1_id;
  assign bus3.rs2_id = rs2_id;           assign bus1.rs2_id = rs2_id;
  assign bus3.rs1_used_id = rs1_used_id; assign bus1.rs1_used_id = rs1_used_id;
  assign bus3.rs2_used_id = rs2_used_id; assign bus1.rs2_used_id = rs2_used_id;
  assign bus3.mem_read_ex = mem_read_ex; assign bus1.mem_read_ex = mem_read_ex;
  assign bus3.branch_taken_ex = branch_taken_ex;
  assign bus1.branch_taken_ex = branch_taken_ex;
  assign bus3.mem_access_mem = mem_access_mem;
  assign bus1.mem_access_mem = mem_access_mem;

`ifdef STALL_STATS_EN
  logic [31:0] stall_cycles3, flush_count3, stall_cycles1, flush_count1;
`endif

  pipeline_stall_controller #(.REG_ADDR_W(5), .MEM_LATENCY(3), .CNT_W(32)) dut3 (
    .clk(clk),
    .arst_n(arst_n),
`ifdef STALL_STATS_EN
    .stall_cycles(stall_cycles3),
    .flush_count(flush_count3),
`endif
    .sc(bus3)
  );

  pipeline_stall_controller #(.REG_ADDR_W(5), .MEM_LATENCY(1), .CNT_W(32)) dut1 (
    .clk(clk),
    .arst_n(arst_n),
`ifdef STALL_STATS_EN
    .stall_cycles(stall_cycles1),
    .flush_count(flush_count1),
`endif
    .sc(bus1)
  );

  function automatic logic [7:0] vec3();
    return {bus3.pc_write, bus3.if_id_write, bus3.if_id_flush, bus3.id_ex_write,
            bus3.id_ex_bubble, bus3.ex_mem_write, bus3.mem_wb_bubble, bus3.busy};
  endfunction

  function automatic logic [7:0] vec1();
    return {bus1.pc_write, bus1.if_id_write, bus1.if_id_flush, bus1.id_ex_write,
            bus1.id_ex_bubble, bus1.ex_mem_write, bus1.mem_wb_bubble, bus1.busy};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    rd_ex = 5'd0; rs1_id = 5'd0; rs2_id = 5'd0;
    rs1_used_id = 1'b0; rs2_used_id = 1'b0; mem_read_ex = 1'b0;
    branch_taken_ex = 1'b0; mem_access_mem = 1'b0;
  endtask

  // Advance to the next cycle: inputs change after the falling edge, checks follow #1 later.
  task automatic next_cyc();
    @(negedge clk);
  endtask

  initial begin
    arst_n = 1'b0;
    idle_in();
    mem_access_mem = 1'b1;
    next_cyc(); #1;
    chk("rst_forced_idle", {24'd0, vec3()}, {24'd0, V_IDLE});
    next_cyc();
    arst_n = 1'b1;
    idle_in(); #1;
    chk("post_rst_idle", {24'd0, vec3()}, {24'd0, V_IDLE});

    // load-use on rs1
    next_cyc();
    mem_read_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; rs1_used_id = 1'b1; #1;
    chk("lu_rs1", {24'd0, vec3()}, {24'd0, V_LU});
    next_cyc(); idle_in(); #1;
    chk("lu_next_idle", {24'd0, vec3()}, {24'd0, V_IDLE});

    // load-use on rs2
    next_cyc();
    mem_read_ex = 1'b1; rd_ex = 5'd9; rs1_id = 5'd3; rs2_id = 5'd9;
    rs1_used_id = 1'b1; rs2_used_id = 1'b1; #1;
    chk("lu_rs2", {24'd0, vec3()}, {24'd0, V_LU});

    // x0 destination never stalls
    next_cyc(); idle_in();
    mem_read_ex = 1'b1; rs1_used_id = 1'b1; #1;
    chk("lu_x0", {24'd0, vec3()}, {24'd0, V_IDLE});

    // matching rs2 not read
    next_cyc(); idle_in();
    mem_read_ex = 1'b1; rd_ex = 5'd7; rs2_id = 5'd7; rs1_id = 5'd1; rs1_used_id = 1'b1; #1;
    chk("lu_rs2_unused", {24'd0, vec3()}, {24'd0, V_IDLE});

    // match without a load
    next_cyc(); idle_in();
    rd_ex = 5'd4; rs1_id = 5'd4; rs1_used_id = 1'b1; #1;
    chk("no_load", {24'd0, vec3()}, {24'd0, V_IDLE});

    // branch overrides load-use
    next_cyc(); idle_in();
    mem_read_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; rs1_used_id = 1'b1; branch_taken_ex = 1'b1; #1;
    chk("br_over_lu", {24'd0, vec3()}, {24'd0, V_BR});

    // memory access, latency 3 vs 1
    next_cyc(); idle_in(); mem_access_mem = 1'b1; #1;
    chk("mem_c1", {24'd0, vec3()}, {24'd0, V_FRZ});
    chk("mem_l1_c1", {24'd0, vec1()}, {24'd0, V_IDLE});
    next_cyc(); #1;
    chk("mem_c2", {24'd0, vec3()}, {24'd0, V_FRZ_B});
    chk("mem_l1_c2", {24'd0, vec1()}, {24'd0, V_IDLE});
    next_cyc(); #1;
    chk("mem_c3_rel", {24'd0, vec3()}, {24'd0, V_REL});
    chk("mem_l1_c3", {24'd0, vec1()}, {24'd0, V_IDLE});
    next_cyc(); mem_access_mem = 1'b0; #1;
    chk("mem_c4_run", {24'd0, vec3()}, {24'd0, V_IDLE});

    // branch held through a freeze acts only at release
    next_cyc(); mem_access_mem = 1'b1; branch_taken_ex = 1'b1; #1;
    chk("brf_c1", {24'd0, vec3()}, {24'd0, V_FRZ});
    chk("brf_l1", {24'd0, vec1()}, {24'd0, V_BR});
    next_cyc(); #1;
    chk("brf_c2", {24'd0, vec3()}, {24'd0, V_FRZ_B});
    next_cyc(); #1;
    chk("brf_c3_rel", {24'd0, vec3()}, {24'd0, V_REL_BR});
    next_cyc(); idle_in(); #1;
    chk("brf_after", {24'd0, vec3()}, {24'd0, V_IDLE});

    // back-to-back accesses re-trigger right after release
    next_cyc(); mem_access_mem = 1'b1; #1;
    chk("b2b_c1", {24'd0, vec3()}, {24'd0, V_FRZ});
    next_cyc(); #1;
    chk("b2b_c2", {24'd0, vec3()}, {24'd0, V_FRZ_B});
    next_cyc(); #1;
    chk("b2b_rel1", {24'd0, vec3()}, {24'd0, V_REL});
    next_cyc(); #1;
    chk("b2b_c4", {24'd0, vec3()}, {24'd0, V_FRZ});
    next_cyc(); #1;
    chk("b2b_c5", {24'd0, vec3()}, {24'd0, V_FRZ_B});
    next_cyc(); #1;
    chk("b2b_rel2", {24'd0, vec3()}, {24'd0, V_REL});

    // reset in the middle of a wait
    next_cyc(); #1;
    chk("rmw_c1", {24'd0, vec3()}, {24'd0, V_FRZ});
    next_cyc(); #1;
    chk("rmw_wait", {24'd0, vec3()}, {24'd0, V_FRZ_B});
    arst_n = 1'b0; #1;
    chk("rmw_forced", {24'd0, vec3()}, {24'd0, V_IDLE});
    next_cyc(); arst_n = 1'b1; idle_in(); #1;
    chk("rmw_after", {24'd0, vec3()}, {24'd0, V_IDLE});
`ifdef STALL_STATS_EN
    chk("stats_stall_clr", stall_cycles3, 32'd0);
    chk("stats_flush_clr", flush_count3, 32'd0);
    mem_read_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; rs1_used_id = 1'b1;
    next_cyc(); idle_in(); branch_taken_ex = 1'b1;
    next_cyc(); idle_in(); #1;
    chk("stats_stall_one", stall_cycles3, 32'd1);
    chk("stats_flush_one", flush_count3, 32'd1);
`endif
    next_cyc(); #1;
    chk("end_idle", {24'd0, vec3()}, {24'd0, V_IDLE});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Merges three stall sources into one set of pipeline-register write enables and bubble/flush controls:
  - load-use hazards (ID vs EX);
  - taken-branch flushes resolved in EX;
  - multi-cycle data-memory accesses in MEM, timed by an internal latency counter.
- Sits beside the datapath and drives PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
- REG_ADDR_W, 5, register-index width.
- MEM_LATENCY, 3, cycles one data-memory access occupies MEM; legal range 1..15.
- CNT_W, 32, stall-statistics counter width; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- arst_n  in  1  reset; synchronous, active-low.
- rd_ex  in  REG_ADDR_W  destination register of the instruction in EX.
- rs1_id  in  REG_ADDR_W  source 1 of the instruction in ID.
- rs2_id  in  REG_ADDR_W  source 2 of the instruction in ID.
- rs1_used_id  in  1  ID instruction reads rs1.
- rs2_used_id  in  1  ID instruction reads rs2.
- mem_read_ex  in  1  EX instruction is a load.
- branch_taken_ex  in  1  EX branch resolved taken.
- mem_access_mem  in  1  MEM instruction is a load or store.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  clear IF/ID to NOP.
- id_ex_write  out  1  ID/EX load enable.
- id_ex_bubble  out  1  select NOP control into ID/EX.
- ex_mem_write  out  1  EX/MEM load enable.
- mem_wb_bubble  out  1  load NOP into MEM/WB.
- busy  out  1  FSM not in S_RUN.

Behaviour:
- Clock and reset: one clock, clk. arst_n is synchronous and active-low, sampled on the rising clk edge.
- Reset:
  - While arst_n=0, outputs are forced to idle values: all *_write=1, if_id_flush=0, id_ex_bubble=0, mem_wb_bubble=0, busy=0.
  - At the next edge with arst_n=0: state<=S_RUN, wait counter<=0.
  - Reset mid-wait abandons the wait; no residual stall after release.
- Outputs are combinational from state, wait counter and inputs; no added latency.
- Load-use hazard (lu):
  - lu = mem_read_ex & (rd_ex!=0) & ((rs1_used_id & rd_ex==rs1_id) | (rs2_used_id & rd_ex==rs2_id)).
  - Writes to x0 never stall.
- FSM states: S_RUN (0), S_MEM_WAIT (1); 4-bit wait counter.
- Memory freeze = pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_write=0, mem_wb_bubble=1, if_id_flush=0, id_ex_bubble=0.
- S_RUN, priority order:
  1. mem_access_mem & MEM_LATENCY>1: memory freeze; counter<=MEM_LATENCY-2; next S_MEM_WAIT.
  2. Else branch_taken_ex: pc_write=1, if_id_flush=1, id_ex_bubble=1. Branch overrides lu, since the ID instruction is discarded.
  3. Else lu: pc_write=0, if_id_write=0, id_ex_bubble=1; all other registers advance. Exactly one bubble per hazard: the next cycle the load sits in MEM and lu is false.
  4. Else: idle values.
- S_MEM_WAIT:
  - counter!=0: memory freeze; counter decrements.
  - counter==0: release cycle. Access completes, mem_access_mem is ignored (no retrigger), next S_RUN, and items 2–4 of S_RUN apply in this cycle.
- Total frozen cycles per access = MEM_LATENCY-1. Back-to-back accesses stall independently; the release cycle of one is immediately followed by the trigger of the next.
- MEM_LATENCY=1: the FSM never leaves S_RUN.
- A branch or lu arriving during a freeze is held by the frozen registers and acted on in the release cycle.
- busy=1 exactly while in S_MEM_WAIT.

Optional Feature:
- Macro: STALL_STATS_EN.
- Defined: adds outputs stall_cycles (CNT_W) and flush_count (CNT_W).
  - stall_cycles increments on every cycle with pc_write=0.
  - flush_count increments on every cycle with if_id_flush=1.
  - Both saturate at all-ones and clear on reset.
- Undefined: these ports and their counters are absent; all other behaviour is identical.

Test Plan:
1. Load-use: mem_read_ex=1, rd_ex=5, rs1_id=5, rs1_used_id=1 for one cycle -> that cycle pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle (inputs idle) all idle values.
2. x0 / unused operand: rd_ex=0=rs1_id, or rs2 match with rs2_used_id=0 -> no stall.
3. Memory latency, MEM_LATENCY=3: mem_access_mem=1 held 3 cycles -> freeze on cycles 1–2 with busy=0 then 1; cycle 3 release with busy=1; cycle 4 S_RUN, busy=0. Repeat with MEM_LATENCY=1 -> no freeze.
4. Branch vs load-use: branch_taken_ex=1 with lu true -> pc_write=1, if_id_flush=1, id_ex_bubble=1, if_id_write=1.
5. Branch during freeze (MEM_LATENCY=3): branch_taken_ex=1 throughout the access -> flush asserted only in the release cycle.
6. Reset mid-wait: arst_n=0 for one edge while in S_MEM_WAIT -> next cycle S_RUN, busy=0, all idle values. With STALL_STATS_EN: stall_cycles and flush_count read 0.
